// File: rtl/pe_weight_loader.sv
// Purpose: sequences a signed weight stream onto the shared PE weight-load bus, PE-major within each slot.
// Latency: 1 cycle from accepted beat to weight_load/weight_load_en/weight_load_sel.
// Backpressure: w_ready is high only in LOAD without abort; the stream is stalled in IDLE and DONE.
module pe_weight_loader #(
    parameter int NUM_PE = 9,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        nbuf,
    input  logic              abort,
    input  logic              w_valid,
    input  logic [WIDTH-1:0]  w_data,
    output logic              w_ready,
    output logic [WIDTH-1:0]  weight_load,
    output logic [NUM_PE-1:0] weight_load_en,
    output logic [1:0]        weight_load_sel,
    output logic              busy,
    output logic              done
);

    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [PW-1:0] PE_LAST = PW'(NUM_PE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pe_cnt, pe_cnt_nxt;
    logic [1:0]      sel_cnt, sel_cnt_nxt;
    logic [1:0]      nbuf_r, nbuf_r_nxt;
    logic            beat_acc;
    logic            last_beat;
    logic [NUM_PE-1:0] en_nxt;

    assign w_ready   = (state == LOAD) && !abort;
    assign beat_acc  = w_ready && w_valid;
    assign last_beat = (sel_cnt == nbuf_r) && (pe_cnt == PE_LAST);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pe_cnt  <= '0;
            sel_cnt <= '0;
            nbuf_r  <= '0;
        end else begin
            state   <= state_nxt;
            pe_cnt  <= pe_cnt_nxt;
            sel_cnt <= sel_cnt_nxt;
            nbuf_r  <= nbuf_r_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pe_cnt_nxt  = pe_cnt;
        sel_cnt_nxt = sel_cnt;
        nbuf_r_nxt  = nbuf_r;
        en_nxt      = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = LOAD;
                    nbuf_r_nxt  = nbuf;
                    pe_cnt_nxt  = '0;
                    sel_cnt_nxt = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    pe_cnt_nxt  = '0;
                    sel_cnt_nxt = '0;
                end else if (beat_acc) begin
                    en_nxt = NUM_PE'(1) << pe_cnt;
                    if (last_beat) begin
                        state_nxt   = DONE;
                        pe_cnt_nxt  = '0;
                        sel_cnt_nxt = '0;
                    end else if (pe_cnt == PE_LAST) begin
                        pe_cnt_nxt  = '0;
                        sel_cnt_nxt = sel_cnt + 2'd1;
                    end else begin
                        pe_cnt_nxt  = pe_cnt + PW'(1);
                    end
                end
            end
            DONE: begin
                // Start is deliberately dropped here; only IDLE samples it.
                state_nxt   = IDLE;
                pe_cnt_nxt  = '0;
                sel_cnt_nxt = '0;
            end
            default: begin
                state_nxt   = IDLE;
                pe_cnt_nxt  = '0;
                sel_cnt_nxt = '0;
            end
        endcase
    end

    // Bus data and slot select hold their last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_load     <= '0;
            weight_load_en  <= '0;
            weight_load_sel <= '0;
        end else begin
            weight_load_en <= en_nxt;
            if (beat_acc) begin
                weight_load     <= w_data;
                weight_load_sel <= sel_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Randomized and directed stimulus for pe_weight_loader against a beat-index job model.
module tb_pe_weight_loader;

    localparam int NUM_PE = 9;
    localparam int WIDTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        nbuf = 2'd0;
    logic              abort = 1'b0;
    logic              w_valid = 1'b0;
    logic [WIDTH-1:0]  w_data = '0;
    logic              w_ready;
    logic [WIDTH-1:0]  weight_load;
    logic [NUM_PE-1:0] weight_load_en;
    logic [1:0]        weight_load_sel;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    // Reference model: a job is a count of beats; the bus position is derived from the beat index.
    bit                m_busy = 0;
    bit                m_loading = 0;
    int                m_idx = 0;
    int                m_len = 0;
    logic [WIDTH-1:0]  m_wl = '0;
    logic [NUM_PE-1:0] m_en = '0;
    logic [1:0]        m_sel = '0;
    int                done_seen = 0;

    pe_weight_loader #(.NUM_PE(NUM_PE), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .nbuf            (nbuf),
        .abort           (abort),
        .w_valid         (w_valid),
        .w_data          (w_data),
        .w_ready         (w_ready),
        .weight_load     (weight_load),
        .weight_load_en  (weight_load_en),
        .weight_load_sel (weight_load_sel),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_loading = 0; m_idx = 0; m_len = 0;
        m_wl = '0; m_en = '0; m_sel = '0;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".weight_load"}, 32'(weight_load), 32'(m_wl));
        chk({ctx, ".en"},          32'(weight_load_en), 32'(m_en));
        chk({ctx, ".sel"},         32'(weight_load_sel), 32'(m_sel));
        chk({ctx, ".busy"},        32'(busy), 32'(m_busy));
        chk({ctx, ".done"},        32'(done), 32'(m_busy && !m_loading));
    endtask

    // One clock: drive inputs, check ready mid-cycle, advance model, check registered outputs.
    task automatic step(input logic s, input logic [1:0] nb, input logic ab,
                        input logic v, input logic [WIDTH-1:0] d);
        start = s; nbuf = nb; abort = ab; w_valid = v; w_data = d;
        @(negedge clk);
        chk("w_ready", 32'(w_ready), 32'(m_loading && !ab));
        m_en = '0;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_loading = 1; m_idx = 0;
                m_len = NUM_PE * (int'(nb) + 1);
            end
        end else if (!m_loading) begin
            m_busy = 0;
        end else if (ab) begin
            m_busy = 0; m_loading = 0;
        end else if (v) begin
            m_en[m_idx % NUM_PE] = 1'b1;
            m_sel = 2'(m_idx / NUM_PE);
            m_wl  = d;
            m_idx++;
            if (m_idx == m_len) m_loading = 0;
        end
        @(posedge clk);
        #1;
        if (done) done_seen++;
        check_outputs("cyc");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Power-on reset.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // 1: reset asserted in the middle of a job.
        step(1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd2, 1'b0, 1'b1, 8'(8'h30 + i));
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // 2: single slot, back-to-back beats 1..9.
        done_seen = 0;
        step(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < NUM_PE; k++) step(1'b0, 2'd0, 1'b0, 1'b1, 8'(k + 1));
        chk("t2_last_en", 32'(weight_load_en), 32'h100);
        chk("t2_done", 32'(done), 32'd1);
        idle_cycles(2);
        chk("t2_done_cnt", 32'(done_seen), 32'd1);

        // 3: four slots with w_valid toggling.
        done_seen = 0;
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 2 * 4 * NUM_PE; k++)
            step(1'b0, 2'd3, 1'b0, (k % 2 == 0), 8'($urandom));
        idle_cycles(3);
        chk("t3_done_cnt", 32'(done_seen), 32'd1);

        // 4: abort at beat 5 of a two-slot job, then replay.
        done_seen = 0;
        step(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b0, 2'd1, 1'b0, 1'b1, 8'(8'h50 + k));
        step(1'b0, 2'd1, 1'b1, 1'b1, 8'h55);
        chk("t4_en_after_abort", 32'(weight_load_en), 32'd0);
        chk("t4_busy_after_abort", 32'(busy), 32'd0);
        idle_cycles(1);
        chk("t4_no_done", 32'(done_seen), 32'd0);
        step(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'd1, 1'b0, 1'b1, 8'h61);
        chk("t4_replay_en", 32'(weight_load_en), 32'h001);
        chk("t4_replay_sel", 32'(weight_load_sel), 32'd0);
        for (int k = 1; k < 2 * NUM_PE; k++) step(1'b0, 2'd1, 1'b0, 1'b1, 8'(8'h61 + k));
        idle_cycles(2);
        chk("t4_replay_done", 32'(done_seen), 32'd1);

        // 5: start held high through the job and its DONE cycle.
        done_seen = 0;
        step(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < NUM_PE; k++) step(1'b1, 2'd3, 1'b0, 1'b1, 8'(8'h70 + k));
        step(1'b1, 2'd3, 1'b0, 1'b1, 8'h7f);
        chk("t5_busy_after_done", 32'(busy), 32'd0);
        idle_cycles(3);
        chk("t5_done_cnt", 32'(done_seen), 32'd1);

        // 6: signed extremes pass through bit-exact and hold across gaps.
        step(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'd0, 1'b0, 1'b1, 8'h80);
        chk("t6_0x80", 32'(weight_load), 32'h80);
        step(1'b0, 2'd0, 1'b0, 1'b0, 8'h11);
        chk("t6_hold", 32'(weight_load), 32'h80);
        step(1'b0, 2'd0, 1'b0, 1'b1, 8'h7f);
        step(1'b0, 2'd0, 1'b0, 1'b1, 8'hff);
        chk("t6_0xff", 32'(weight_load), 32'hff);
        for (int k = 3; k < NUM_PE; k++) step(1'b0, 2'd0, 1'b0, 1'b1, 8'($urandom));
        idle_cycles(2);

        // Random jobs with random gaps, stray starts and occasional aborts.
        for (int j = 0; j < 12; j++) begin
            int n;
            logic [1:0] nb;
            nb = 2'($urandom_range(0, 3));
            step(1'b1, nb, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            n = 0;
            while (m_busy && n < 300) begin
                step(($urandom_range(0, 7) == 0), 2'($urandom),
                     ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                     8'($urandom));
                n++;
            end
            chk("rand_job_ended", 32'(m_busy), 32'd0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
